// File: rtl/gerador_perda_vida.sv
`timescale 1ns / 1ps
// Collision event stage for the 3-bit life counter: synchronizes and debounces a raw
// collision input, emits one registered loss pulse, then opens an invulnerability window.
module gerador_perda_vida #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned INVULN_CYCLES   = 16,
  parameter int unsigned MAX_PERDAS      = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       colisao,
  input  logic       jogo_ativo,
  input  logic [2:0] vidas,
  output logic       perda_vida,
  output logic       invulneravel,
  output logic       fim_de_jogo,
  output logic [2:0] estado
);

  localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TmrW = $clog2(INVULN_CYCLES + 1);

  localparam logic [DebW-1:0] DebMax       = DebW'(DEBOUNCE_CYCLES);
  localparam logic [DebW-1:0] DebLast      = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmrW-1:0] TmrMax       = TmrW'(INVULN_CYCLES);
  localparam logic [2:0]      GameOverCode = 3'(MAX_PERDAS);

  typedef enum logic [2:0] {
    StOcioso         = 3'd0,
    StFiltrando      = 3'd1,
    StPulso          = 3'd2,
    StInvulneravel   = 3'd3,
    StAguardaSoltar  = 3'd4,
    StFim            = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [DebW-1:0]       deb_q, deb_d;
  logic [TmrW-1:0]       tmr_q, tmr_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                  colisao_s;

  assign colisao_s = sync_q[SYNC_STAGES-1];
  assign estado    = state_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], colisao};
    end
  end

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    tmr_d   = tmr_q;
    if (state_q == StFim) begin
      state_d = StFim;
    // Skipped in PULSO: the counter only updates on the perda_vida edge itself.
    end else if (state_q != StPulso && vidas == GameOverCode) begin
      state_d = StFim;
      deb_d   = '0;
      tmr_d   = '0;
    end else if (!jogo_ativo) begin
      state_d = StOcioso;
      deb_d   = '0;
      tmr_d   = '0;
    end else begin
      unique case (state_q)
        StOcioso: begin
          if (colisao_s) begin
            if (DEBOUNCE_CYCLES <= 1) begin
              state_d = StPulso;
              deb_d   = DebMax;
            end else begin
              state_d = StFiltrando;
              deb_d   = DebW'(1);
            end
          end
        end
        StFiltrando: begin
          if (!colisao_s) begin
            state_d = StOcioso;
            deb_d   = '0;
          end else if (deb_q >= DebLast) begin
            // This sample completes the run of consecutive high samples.
            state_d = StPulso;
            deb_d   = DebMax;
          end else begin
            deb_d = deb_q + DebW'(1);
          end
        end
        StPulso: begin
          state_d = StInvulneravel;
          deb_d   = '0;
          tmr_d   = TmrMax;
        end
        StInvulneravel: begin
          if (tmr_q <= TmrW'(1)) begin
            state_d = StAguardaSoltar;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q - TmrW'(1);
          end
        end
        StAguardaSoltar: begin
          if (!colisao_s) state_d = StOcioso;
        end
        default: begin
          state_d = StOcioso;
          deb_d   = '0;
          tmr_d   = '0;
        end
      endcase
    end
  end

  // Outputs decoded from the next state so each one comes straight from a flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StOcioso;
      deb_q        <= '0;
      tmr_q        <= '0;
      perda_vida   <= 1'b0;
      invulneravel <= 1'b0;
      fim_de_jogo  <= 1'b0;
    end else begin
      state_q      <= state_d;
      deb_q        <= deb_d;
      tmr_q        <= tmr_d;
      perda_vida   <= (state_d == StPulso);
      invulneravel <= (state_d == StInvulneravel);
      fim_de_jogo  <= (state_d == StFim);
    end
  end

endmodule

// File: tb/tb_gerador_perda_vida.sv
`timescale 1ns / 1ps
// Scoreboard bench for gerador_perda_vida: a rule-level model predicts pulses and status,
// a monitor compares them at each falling edge; a saturating life counter closes the loop.
module tb_gerador_perda_vida;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int INV  = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cnt_rst = 1'b1;
  logic       colisao = 1'b0;
  logic       jogo_ativo = 1'b0;
  logic [2:0] vidas;
  logic       perda_vida, invulneravel, fim_de_jogo;
  logic [2:0] estado;

  always #5 clock = ~clock;

  gerador_perda_vida dut (
    .clock        (clock),
    .reset        (reset),
    .colisao      (colisao),
    .jogo_ativo   (jogo_ativo),
    .vidas        (vidas),
    .perda_vida   (perda_vida),
    .invulneravel (invulneravel),
    .fim_de_jogo  (fim_de_jogo),
    .estado       (estado)
  );

  // Life counter clocked by the loss pulse, saturating at 7.
  always @(posedge perda_vida or negedge cnt_rst) begin
    if (!cnt_rst) vidas <= 3'd0;
    else if (vidas != 3'd7) vidas <= vidas + 3'd1;
  end

  int n_checks = 0;
  int n_fail = 0;
  int edge_n = 0;
  int pulses_seen = 0;

  always @(posedge clock) edge_n <= edge_n + 1;

  typedef struct {
    logic       pulse;
    logic       inv;
    logic       fim;
    logic [2:0] st;
  } status_t;

  status_t st_q[$];
  int      pulse_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin : monitor
    status_t s;
    if (st_q.size() > 0) begin
      s = st_q.pop_front();
      if (reset) begin
        check("perda_vida", 32'(perda_vida), 32'(s.pulse));
        check("invulneravel", 32'(invulneravel), 32'(s.inv));
        check("fim_de_jogo", 32'(fim_de_jogo), 32'(s.fim));
        check("estado", 32'(estado), 32'(s.st));
      end
    end
    if (reset && perda_vida === 1'b1) begin
      pulses_seen++;
      if (pulse_q.size() == 0) check("unexpected_pulse_edge", 32'(edge_n), 32'hFFFF_FFFF);
      else check("pulse_edge", 32'(edge_n), 32'(pulse_q.pop_front()));
    end
  end

  // Reference model: counts of consecutive accepted samples and remaining window cycles.
  logic hist[$];
  int   m_over, m_win, m_await, m_run, m_pulse;

  task automatic model_clear();
    m_over = 0; m_win = 0; m_await = 0; m_run = 0; m_pulse = 0;
    hist.delete();
    st_q.delete();
    pulse_q.delete();
  endtask

  // Apply inputs for the coming rising edge and record what the model expects after it.
  task automatic drive(input logic c, input logic ja);
    logic    cs;
    int      pulse_prev;
    status_t s;
    colisao    = c;
    jogo_ativo = ja;
    hist.push_back(c);
    if (hist.size() > SYNC + 1) void'(hist.pop_front());
    cs = (hist.size() == SYNC + 1) ? hist[0] : 1'b0;
    pulse_prev = m_pulse;
    m_pulse = 0;
    if (m_over != 0) begin
    end else if (pulse_prev == 0 && vidas == 3'd7) begin
      m_over = 1; m_win = 0; m_await = 0; m_run = 0;
    end else if (!ja) begin
      m_win = 0; m_await = 0; m_run = 0;
    end else if (pulse_prev != 0) begin
      m_win = INV;
    end else if (m_win > 0) begin
      if (m_win == 1) begin
        m_win = 0; m_await = 1;
      end else begin
        m_win--;
      end
    end else if (m_await != 0) begin
      if (!cs) m_await = 0;
    end else if (cs) begin
      m_run++;
      if (m_run >= DEB) begin
        m_run = 0; m_pulse = 1;
      end
    end else begin
      m_run = 0;
    end
    s.pulse = (m_pulse != 0);
    s.inv   = (m_win > 0);
    s.fim   = (m_over != 0);
    s.st    = (m_over != 0) ? 3'd5 : (m_pulse != 0) ? 3'd2 : (m_win > 0) ? 3'd3 :
              (m_await != 0) ? 3'd4 : (m_run > 0) ? 3'd1 : 3'd0;
    st_q.push_back(s);
    if (m_pulse != 0) pulse_q.push_back(edge_n + 1);
  endtask

  task automatic step(input logic c, input logic ja);
    drive(c, ja);
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    check("pending_pulses", 32'(pulse_q.size()), 32'd0);
    reset = 1'b0;
    cnt_rst = 1'b0;
    colisao = 1'b0;
    jogo_ativo = 1'b0;
    #1;
    model_clear();
    repeat (2) @(negedge clock);
    #1;
    check("rst_perda_vida", 32'(perda_vida), 32'd0);
    check("rst_invulneravel", 32'(invulneravel), 32'd0);
    check("rst_fim_de_jogo", 32'(fim_de_jogo), 32'd0);
    check("rst_estado", 32'(estado), 32'd0);
    reset = 1'b1;
    cnt_rst = 1'b1;
  endtask

  // Assumes drive() was just called; hits reset between the next rising and falling edges.
  task automatic async_reset_check(input bit in_pulse);
    @(posedge clock);
    #1;
    if (in_pulse) check("pre_async_perda_vida", 32'(perda_vida), 32'd1);
    else check("pre_async_fim_de_jogo", 32'(fim_de_jogo), 32'd1);
    #1;
    reset = 1'b0;
    cnt_rst = 1'b0;
    #1;
    check("async_perda_vida", 32'(perda_vida), 32'd0);
    check("async_invulneravel", 32'(invulneravel), 32'd0);
    check("async_fim_de_jogo", 32'(fim_de_jogo), 32'd0);
    check("async_estado", 32'(estado), 32'd0);
    model_clear();
    @(negedge clock);
    #1;
    reset = 1'b1;
    cnt_rst = 1'b1;
    step(1'b0, 1'b1);
    check("post_async_estado", 32'(estado), 32'd0);
  endtask

  initial begin
    int first_lat, inv_cnt, p_cnt, p0, len;
    bit found;
    logic c, ja;
    #1;
    do_reset();

    // T1: held contact, latency, window length, wait-for-release
    first_lat = -1; inv_cnt = 0; p_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1'b1);
      if (perda_vida === 1'b1) begin
        p_cnt++;
        if (first_lat < 0) first_lat = i;
      end
      if (invulneravel === 1'b1) inv_cnt++;
    end
    check("t1_latency_edges", 32'(first_lat), 32'd6);
    check("t1_pulse_count", 32'(p_cnt), 32'd1);
    check("t1_window_cycles", 32'(inv_cnt), 32'(INV));
    check("t1_hold_estado", 32'(estado), 32'd4);
    repeat (4) step(1'b0, 1'b1);
    check("t1_release_estado", 32'(estado), 32'd0);

    // T2: short glitches
    do_reset();
    p0 = pulses_seen;
    repeat (3) step(1'b0, 1'b1);
    for (int w = 1; w <= 3; w++) begin
      repeat (w) step(1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b1);
    end
    repeat (4) step(1'b0, 1'b1);
    check("t2_no_pulse", 32'(pulses_seen - p0), 32'd0);
    check("t2_estado", 32'(estado), 32'd0);

    // T4: second contact inside the window
    do_reset();
    p0 = pulses_seen;
    repeat (8) step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    repeat (25) step(1'b1, 1'b1);
    check("t4_window_hit_ignored", 32'(pulses_seen - p0), 32'd1);
    repeat (5) step(1'b0, 1'b1);
    repeat (10) step(1'b1, 1'b1);
    check("t4_new_hit_fires", 32'(pulses_seen - p0), 32'd2);

    // T5: game paused while filtering, while idle, and inside the window
    do_reset();
    p0 = pulses_seen;
    repeat (4) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("t5_filter_abort_estado", 32'(estado), 32'd0);
    repeat (10) step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b1);
    repeat (10) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("t5_window_abort_estado", 32'(estado), 32'd0);
    check("t5_window_abort_inv", 32'(invulneravel), 32'd0);
    check("t5_pulse_count", 32'(pulses_seen - p0), 32'd1);
    repeat (2) step(1'b0, 1'b1);

    // T6a: async reset while the pulse is high
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(1'b1, 1'b1);
      if (m_pulse != 0) begin
        found = 1'b1;
        async_reset_check(1'b1);
      end else begin
        @(negedge clock);
        #1;
      end
    end
    check("t6_reached_pulso", 32'(found), 32'd1);

    // T3: seven hits to game over, eighth ignored; then T6b async reset in FIM
    do_reset();
    p0 = pulses_seen;
    for (int h = 0; h < 8; h++) begin
      repeat (30) step(1'b1, 1'b1);
      repeat (5) step(1'b0, 1'b1);
    end
    check("t3_pulse_count", 32'(pulses_seen - p0), 32'd7);
    check("t3_vidas", 32'(vidas), 32'd7);
    check("t3_fim_de_jogo", 32'(fim_de_jogo), 32'd1);
    check("t3_estado", 32'(estado), 32'd5);
    drive(1'b0, 1'b1);
    async_reset_check(1'b0);

    // Random segments against the model
    do_reset();
    for (int seg = 0; seg < 150; seg++) begin
      len = $urandom_range(25, 1);
      c   = 1'($urandom_range(1, 0));
      ja  = ($urandom_range(15, 0) == 0) ? 1'b0 : 1'b1;
      repeat (len) step(c, ja);
      if (m_over != 0 && $urandom_range(3, 0) == 0) do_reset();
    end
    repeat (40) step(1'b0, 1'b1);
    check("final_pending_pulses", 32'(pulse_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
